// File: rtl/mesha_prefetch_queue.sv
// ============================================================================
// Module   : mesha_prefetch_queue
// Brief    : Instruction prefetch queue with single-outstanding fetch FSM and
//            redirect/flush support. Optional same-cycle response bypass is
//            enabled by defining MESHA_PFQ_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mesha_prefetch_queue #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       imem_req,
    output logic [ADDR_WIDTH-1:0]      imem_addr,
    input  logic                       imem_gnt,
    input  logic                       imem_rvalid,
    input  logic [DATA_WIDTH-1:0]      imem_rdata,
    output logic                       out_valid,
    output logic [DATA_WIDTH-1:0]      out_instr,
    output logic [ADDR_WIDTH-1:0]      out_pc,
    input  logic                       out_ready,
    input  logic                       redirect_valid,
    input  logic [ADDR_WIDTH-1:0]      redirect_pc,
    output logic [$clog2(DEPTH):0]     fill_level
);

    localparam int                c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]  c_FULL  = (c_PTR_W+1)'(DEPTH);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_WAIT = 2'd1;
    localparam logic [1:0] c_DROP = 2'd2;

    logic [1:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_fetch_pc;
    logic [ADDR_WIDTH-1:0] r_pend_pc;
    logic [c_PTR_W-1:0]    r_head;
    logic [c_PTR_W-1:0]    r_tail;
    logic [c_PTR_W:0]      r_count;
    logic [DATA_WIDTH-1:0] r_instr_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_pc_mem    [DEPTH];

    logic w_grant;
    logic w_resp;
    logic w_bypass;
    logic w_push;
    logic w_pop;
    logic w_q_valid;

    assign w_q_valid = (r_count != '0);

    // A request is only issued with a free slot, which stays reserved until the response.
    assign imem_req  = !rst && (r_state == c_IDLE) && (r_count < c_FULL) && !redirect_valid;
    assign imem_addr = r_fetch_pc;
    assign w_grant   = imem_req && imem_gnt;
    assign w_resp    = (r_state == c_WAIT) && imem_rvalid && !redirect_valid;

`ifdef MESHA_PFQ_BYPASS_EN
    assign w_bypass = w_resp && !w_q_valid && out_ready;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_push     = w_resp && !w_bypass;
    assign w_pop      = w_q_valid && out_ready && !redirect_valid;
    assign out_valid  = w_q_valid || w_bypass;
    assign fill_level = r_count;

    always_comb begin
        out_instr = '0;
        out_pc    = '0;
        if (w_bypass) begin
            out_instr = imem_rdata;
            out_pc    = r_pend_pc;
        end else if (w_q_valid) begin
            out_instr = r_instr_mem[r_head];
            out_pc    = r_pc_mem[r_head];
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_instr_mem[r_tail] <= imem_rdata;
            r_pc_mem[r_tail]    <= r_pend_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_fetch_pc <= RESET_PC;
            r_pend_pc  <= RESET_PC;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
        end else if (redirect_valid) begin
            r_fetch_pc <= redirect_pc;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            // A response landing with the redirect is simply dropped.
            case (r_state)
                c_WAIT:  r_state <= imem_rvalid ? c_IDLE : c_DROP;
                c_DROP:  if (imem_rvalid) r_state <= c_IDLE;
                default: r_state <= c_IDLE;
            endcase
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_grant) begin
                        r_state    <= c_WAIT;
                        r_pend_pc  <= r_fetch_pc;
                        r_fetch_pc <= r_fetch_pc + ADDR_WIDTH'(4);
                    end
                end
                c_WAIT:  if (imem_rvalid) r_state <= c_IDLE;
                c_DROP:  if (imem_rvalid) r_state <= c_IDLE;
                default: r_state <= c_IDLE;
            endcase

            if (w_push) r_tail <= r_tail + c_PTR_W'(1);
            if (w_pop)  r_head <= r_head + c_PTR_W'(1);

            if (w_push && !w_pop) begin
                r_count <= r_count + (c_PTR_W+1)'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - (c_PTR_W+1)'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mesha_prefetch_queue.sv
// ============================================================================
// Module   : tb_mesha_prefetch_queue
// Brief    : Self-checking bench for mesha_prefetch_queue with a reference
//            memory model and an expected-entry scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mesha_prefetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [2:0]  fill_level;

    mesha_prefetch_queue #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .DEPTH      (DEPTH),
        .RESET_PC   (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_ready      (out_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fill_level     (fill_level)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    typedef struct {
        logic ready;
        logic gnt;
        int   cycles;
        int   exp_fill;
        logic exp_req;
        int   exp_pops;
    } phase_t;

    int   checks = 0;
    int   errors = 0;
    ent_t sb[$];

    // Stimulus controls and reference model state
    logic        ready, gnt, redir;
    logic [31:0] redir_pc;
    int          lat;
    logic        exp_busy, exp_squash;
    logic [31:0] exp_fetch_pc;
    logic        mp_valid;
    logic [31:0] mp_addr;
    int          mp_delay;
    logic        e_deliver, e_byp, e_req, e_grant;
    int          pops;
    logic [31:0] last_pop_pc;
    phase_t      tbl[3];

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a == 32'h20) ? 32'hDEADBEEF : ((a ^ 32'h5A5A_0F0F) + 32'h11);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic eval();
        out_ready      = ready;
        imem_gnt       = gnt;
        redirect_valid = redir;
        redirect_pc    = redir_pc;
        e_deliver      = mp_valid && (mp_delay == 0);
        imem_rvalid    = e_deliver;
        imem_rdata     = e_deliver ? instr_of(mp_addr) : 32'h0;
        #1;
        e_byp = 1'b0;
`ifdef MESHA_PFQ_BYPASS_EN
        e_byp = e_deliver && exp_busy && !exp_squash && !redir && (sb.size() == 0) && ready;
`endif
        e_req = !exp_busy && (sb.size() < DEPTH) && !redir;
        check("fill_level", 64'(fill_level), 64'(sb.size()));
        check("out_valid", 64'(out_valid), 64'((sb.size() != 0) || e_byp));
        check("imem_req", 64'(imem_req), 64'(e_req));
        if (e_req) check("imem_addr", 64'(imem_addr), 64'(exp_fetch_pc));
        if (((sb.size() != 0) || e_byp) && ready && !redir) begin
            if (e_byp) begin
                check("byp_pc", 64'(out_pc), 64'(mp_addr));
                check("byp_instr", 64'(out_instr), 64'(instr_of(mp_addr)));
            end else begin
                check("head_pc", 64'(out_pc), 64'(sb[0].pc));
                check("head_instr", 64'(out_instr), 64'(sb[0].instr));
            end
            last_pop_pc = out_pc;
            pops++;
        end
        e_grant = e_req && gnt;
    endtask

    task automatic commit();
        @(posedge clk);
        if (redir) begin
            sb.delete();
            exp_fetch_pc = redir_pc;
            if (exp_busy) exp_squash = 1'b1;
        end else begin
            if ((sb.size() != 0) && ready) void'(sb.pop_front());
            if (e_deliver && exp_busy && !exp_squash && !e_byp)
                sb.push_back({mp_addr, instr_of(mp_addr)});
        end
        if (e_deliver) begin
            exp_busy = 1'b0;
            mp_valid = 1'b0;
        end else if (mp_valid && mp_delay > 0) begin
            mp_delay--;
        end
        if (e_grant) begin
            exp_busy     = 1'b1;
            exp_squash   = 1'b0;
            mp_valid     = 1'b1;
            mp_addr      = exp_fetch_pc;
            mp_delay     = lat - 1;
            exp_fetch_pc = exp_fetch_pc + 32'd4;
        end
        @(negedge clk);
    endtask

    task automatic step();
        eval();
        commit();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, 64'(out_valid), 64'(0));
        check({tag, "_fill"}, 64'(fill_level), 64'(0));
        check({tag, "_imem_req"}, 64'(imem_req), 64'(0));
        check({tag, "_out_instr"}, 64'(out_instr), 64'(0));
        check({tag, "_out_pc"}, 64'(out_pc), 64'(0));
    endtask

    task automatic model_reset();
        sb.delete();
        exp_busy     = 1'b0;
        exp_squash   = 1'b0;
        exp_fetch_pc = RESET_PC;
    endtask

    initial begin
        // {ready, gnt, cycles, exp_fill, exp_req, exp_pops}
        tbl[0] = '{1'b0, 1'b1, 12, 4, 1'b0, 0};
        tbl[1] = '{1'b1, 1'b0, 4, 0, 1'b1, 4};
`ifdef MESHA_PFQ_BYPASS_EN
        tbl[2] = '{1'b1, 1'b1, 20, 0, 1'b1, 10};
`else
        tbl[2] = '{1'b1, 1'b1, 20, 1, 1'b1, 9};
`endif

        rst = 1'b1;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        ready = 1'b0; gnt = 1'b0; redir = 1'b0; redir_pc = 32'h0; lat = 1;
        mp_valid = 1'b0; mp_addr = 32'h0; mp_delay = 0; pops = 0; last_pop_pc = 32'h0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("rst0");
        rst = 1'b0;

        // Fill to full, drain in order, then sustained streaming
        for (int i = 0; i < 3; i++) begin
            ready = tbl[i].ready;
            gnt   = tbl[i].gnt;
            pops  = 0;
            repeat (tbl[i].cycles) step();
            check($sformatf("ph%0d_fill", i), 64'(fill_level), 64'(tbl[i].exp_fill));
            check($sformatf("ph%0d_req", i), 64'(imem_req), 64'(tbl[i].exp_req));
            check($sformatf("ph%0d_pops", i), 64'(pops), 64'(tbl[i].exp_pops));
        end

        // Redirect while a slow response is outstanding
        ready = 1'b1; gnt = 1'b0;
        step(); step();
        lat = 4; gnt = 1'b1;
        step();
        gnt = 1'b0; redir = 1'b1; redir_pc = 32'h100;
        step();
        redir = 1'b0;
        step(); step(); step();
        check("redir_addr", 64'(imem_addr), 64'(32'h100));
        check("redir_req", 64'(imem_req), 64'(1));
        lat = 1; gnt = 1'b1;
        step(); step();
        gnt = 1'b0;
        step();
        check("redir_first_pc", 64'(last_pop_pc), 64'(32'h100));

        // Redirect coincident with the response
        gnt = 1'b1;
        step();
        gnt = 1'b0; redir = 1'b1; redir_pc = 32'h200;
        eval();
        commit();
        redir = 1'b0;
        eval();
        check("coinc_fill", 64'(fill_level), 64'(0));
        check("coinc_valid", 64'(out_valid), 64'(0));
        check("coinc_req", 64'(imem_req), 64'(1));
        check("coinc_addr", 64'(imem_addr), 64'(32'h200));
        commit();

        // Response visibility relative to the arrival cycle
        redir = 1'b1; redir_pc = 32'h20;
        step();
        redir = 1'b0; gnt = 1'b1; ready = 1'b1;
        step();
        gnt = 1'b0;
        eval();
`ifdef MESHA_PFQ_BYPASS_EN
        check("resp_same_valid", 64'(out_valid), 64'(1));
        check("resp_same_instr", 64'(out_instr), 64'(32'hDEADBEEF));
`else
        check("resp_same_valid", 64'(out_valid), 64'(0));
`endif
        commit();
        eval();
`ifdef MESHA_PFQ_BYPASS_EN
        check("resp_next_valid", 64'(out_valid), 64'(0));
`else
        check("resp_next_valid", 64'(out_valid), 64'(1));
        check("resp_next_instr", 64'(out_instr), 64'(32'hDEADBEEF));
        check("resp_next_pc", 64'(out_pc), 64'(32'h20));
`endif
        commit();

        // Reset while waiting with two entries queued
        ready = 1'b0; gnt = 1'b1; lat = 1;
        repeat (5) step();
        check("pre_rst_fill", 64'(fill_level), 64'(2));
        rst = 1'b1;
        imem_rvalid = 1'b0;
        #1;
        check_reset_outputs("rst1");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        ready = 1'b1; gnt = 1'b1;
        last_pop_pc = 32'hFFFF_FFFF;
        eval();
        check("post_rst_addr", 64'(imem_addr), 64'(RESET_PC));
        commit();
        step(); step();
        check("post_rst_first_pc", 64'(last_pop_pc), 64'(RESET_PC));
        repeat (6) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mesha_prefetch_queue.md
MESHA_PREFETCH_QUEUE -- requirements
Module: mesha_prefetch_queue

Interface
REQ-001 Parameter DATA_WIDTH, default 32, instruction width.
REQ-002 Parameter ADDR_WIDTH, default 32, fetch address width.
REQ-003 Parameter DEPTH, default 4, queue entries; power of two, at least 2.
REQ-004 Parameter RESET_PC, default 0, first fetch address after reset.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 imem_req  output  1  fetch request to instruction memory.
REQ-008 imem_addr  output  ADDR_WIDTH  fetch address; valid while imem_req is high.
REQ-009 imem_gnt  input  1  request accepted in the cycle where imem_req and imem_gnt are both high.
REQ-010 imem_rvalid  input  1  response data valid.
REQ-011 imem_rdata  input  DATA_WIDTH  response instruction word.
REQ-012 out_valid  output  1  head entry available to the pipeline.
REQ-013 out_instr  output  DATA_WIDTH  head instruction.
REQ-014 out_pc  output  ADDR_WIDTH  head instruction address.
REQ-015 out_ready  input  1  consumer accepts the head in the cycle where out_valid and out_ready are both high.
REQ-016 redirect_valid  input  1  flush the queue and restart fetch.
REQ-017 redirect_pc  input  ADDR_WIDTH  new fetch address.
REQ-018 fill_level  output  $clog2(DEPTH)+1  current entry count.

Function
REQ-019 The fetch FSM SHALL have three states: IDLE (nothing outstanding), WAIT (granted request awaiting response) and DROP (squashed request awaiting response).
REQ-020 imem_req SHALL equal (state==IDLE && fill_level<DEPTH && !redirect_valid), combinationally; imem_addr SHALL equal fetch_pc.
REQ-021 On a grant: fetch_pc SHALL become fetch_pc+4 (mod 2^ADDR_WIDTH), the granted address SHALL be latched as pend_pc, and the FSM SHALL go IDLE->WAIT.
REQ-022 At most one request SHALL be outstanding; its queue slot is reserved, so a push never occurs while the queue is full.
REQ-023 imem_rvalid in WAIT without redirect SHALL push {imem_rdata, pend_pc} at the tail and go WAIT->IDLE.
REQ-024 imem_rvalid in DROP SHALL discard the data and go DROP->IDLE; imem_rvalid in IDLE SHALL be ignored.
REQ-025 out_valid SHALL equal (fill_level!=0); out_instr and out_pc SHALL show the head entry; a handshake pops the head.
REQ-026 A simultaneous push and pop SHALL leave fill_level unchanged; head and tail pointers SHALL wrap modulo DEPTH.
REQ-027 redirect_valid SHALL clear all entries, set fetch_pc=redirect_pc, move WAIT->DROP, and leave IDLE and DROP unchanged; it overrides push, pop and grant in that cycle.
REQ-028 redirect_valid coincident with imem_rvalid in WAIT SHALL discard the data and go to IDLE.
REQ-029 With a zero-latency memory (gnt every cycle, rvalid the next cycle) and out_ready held high, sustained throughput SHALL be one instruction every 2 cycles.

Reset
REQ-030 While rst is high: state=IDLE, fetch_pc=RESET_PC, pointers=0, fill_level=0, out_valid=0, imem_req=0, out_instr=0, out_pc=0.
REQ-031 Reset asserted mid-request SHALL abandon the request; a response arriving after deassertion SHALL be ignored because the FSM is in IDLE.

Configuration
REQ-032 Macro MESHA_PFQ_BYPASS_EN: when defined, an imem_rvalid in WAIT with the queue empty and out_ready high SHALL present the data on out_valid/out_instr/out_pc in the same cycle, without writing the queue.
REQ-033 When MESHA_PFQ_BYPASS_EN is undefined, every response SHALL be written to the queue first and become visible on the following cycle.

Verification
REQ-034 Reset release, memory grants immediately and returns on the next cycle, out_ready=1 -> out_pc sequence 0x0, 0x4, 0x8, ... with matching instructions.
REQ-035 out_ready=0 with DEPTH=4 -> fill_level reaches 4, imem_req drops to 0, and entries drain in order once out_ready=1.
REQ-036 Redirect to 0x100 while in WAIT, response 3 cycles later -> that response is discarded; next imem_addr=0x100; first out_pc=0x100.
REQ-037 redirect_valid in the same cycle as imem_rvalid -> fill_level=0, no out_valid from the old data, FSM returns to IDLE.
REQ-038 rst pulsed while in WAIT with 2 entries queued -> all outputs take reset values; fetch restarts at RESET_PC.
REQ-039 With MESHA_PFQ_BYPASS_EN, empty queue, response 0xDEADBEEF at pc 0x20 -> out_valid=1 and out_instr=0xDEADBEEF in the same cycle; without the macro -> they appear one cycle later.
